// File: rtl/serializer_defs.sv
// Shared definitions for the word serializer.
//   state_t        : serializer FSM state encoding
//   DEFAULT_WIDTH  : default bits per parallel word
package serializer_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/word_hold_buf.sv
// One-entry holding buffer for the word waiting behind the one being shifted out.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset, empties the buffer
//   wr_en    : store wr_data and mark full
//   wr_data  : {msb_first, word}
//   rd_en    : consume the stored entry (marks empty)
//   rd_data  : stored {msb_first, word}
//   full     : an entry is held
module word_hold_buf
    import serializer_defs::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           wr_en,
    input  logic [WIDTH:0] wr_data,
    input  logic           rd_en,
    output logic [WIDTH:0] rd_data,
    output logic           full
);

    logic           r_full;
    logic [WIDTH:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            // A write wins over a simultaneous read so a new word is never lost.
            if (wr_en) begin
                r_full <= 1'b1;
                r_data <= wr_data;
            end else if (rd_en) begin
                r_full <= 1'b0;
            end
        end
    end

    assign rd_data = r_data;
    assign full    = r_full;

endmodule

// File: rtl/word_serializer.sv
// Parallel-in / serial-out stage. Takes one WIDTH-bit word per par handshake and emits it one
// bit per cycle on the ser handshake, MSB- or LSB-first as chosen per word. One pending word is
// held so consecutive words stream with no idle cycle.
// Ports:
//   clk, reset_n          : clock (rising edge) and asynchronous active-low reset
//   par_in, par_msb       : parallel word and its bit order (1 = MSB first)
//   par_valid, par_ready  : parallel-side handshake
//   ser_out, ser_last     : current serial bit, and flag for the final bit of its word
//   ser_valid, ser_ready  : serial-side handshake
//   busy                  : a word is being shifted out or is pending
module word_serializer
    import serializer_defs::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] par_in,
    input  logic             par_msb,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic             r_dir, w_dir_nxt;

    logic             w_in_acc, w_bit_acc, w_last, w_shifting;
    logic             w_pend_full, w_pend_wr, w_pend_rd;
    logic [WIDTH:0]   w_pend_rdata;

    word_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_pend_wr),
        .wr_data ({par_msb, par_in}),
        .rd_en   (w_pend_rd),
        .rd_data (w_pend_rdata),
        .full    (w_pend_full)
    );

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last     = (r_cnt == LAST_IDX);
    assign w_in_acc   = par_valid & par_ready;
    assign w_bit_acc  = w_shifting & ser_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shreg <= w_shreg_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_dir_nxt   = r_dir;
        w_pend_wr   = 1'b0;
        w_pend_rd   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_in_acc) begin
                    w_shreg_nxt = par_in;
                    w_dir_nxt   = par_msb;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_bit_acc && !w_last) begin
                    // Move the next bit toward whichever end is emitting.
                    w_shreg_nxt = r_dir ? {r_shreg[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shreg[WIDTH-1:1]};
                    w_cnt_nxt   = r_cnt + 1'b1;
                end else if (w_bit_acc && w_last) begin
                    w_cnt_nxt = '0;
                    if (w_pend_full) begin
                        w_shreg_nxt = w_pend_rdata[WIDTH-1:0];
                        w_dir_nxt   = w_pend_rdata[WIDTH];
                        w_pend_rd   = 1'b1;
                    end else if (w_in_acc) begin
                        // Bypass: the incoming word goes straight into the shifter.
                        w_shreg_nxt = par_in;
                        w_dir_nxt   = par_msb;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                // Any accepted word not taken by the bypass waits in the holding buffer.
                if (w_in_acc && !(w_bit_acc && w_last)) begin
                    w_pend_wr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign par_ready = ~w_pend_full;
    assign ser_valid = w_shifting;
    assign ser_out   = w_shifting & (r_dir ? r_shreg[WIDTH-1] : r_shreg[0]);
    assign ser_last  = w_shifting & w_last;
    assign busy      = w_shifting | w_pend_full;

endmodule
